muldiv_sequencer: RTL and testbench

// - Multi-cycle controller for the HI/LO mult/div resource. Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo decoded by control32.
// - Iterates one shift-add (mult) or restoring-subtract (div) step per cycle and owns the HI/LO registers.
// - Raises stall back to the pipeline while a HI/LO-touching instruction meets a busy unit.

---
 rtl/muldiv_sequencer_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: FSM state encodings,
// accepted operation kinds and small decode helpers.
package muldiv_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_SIGN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_kind_t;

   function automatic logic op_is_div(input op_kind_t kind);
      return (kind == OP_DIV) || (kind == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input op_kind_t kind);
      return (kind == OP_MULT) || (kind == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared work register: LSB-first shift-add for multiply,
// restoring trial-subtract for divide. Upper half = accumulator/remainder.
module muldiv_step
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   work,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   work_next
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   // Evaluate both step flavours and pick the one for the active operation.
   always_comb begin
      sum_s     = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      shifted_s = work[2*WIDTH-1:WIDTH-1];
      diff_s    = shifted_s - {1'b0, opnd};
      if (is_div) begin
         // Negative trial difference means the divisor did not fit: restore.
         if (!diff_s[WIDTH]) begin
            work_next = {diff_s[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
         end else begin
            work_next = {shifted_s[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
         end
      end else begin
         work_next = {sum_s, work[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller: accepts mult/div/mthi/mtlo, iterates one bit per
// cycle on magnitudes, fixes signs in a final cycle and owns the HI/LO registers.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_mult,
   input  logic             op_multu,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic             op_mthi,
   input  logic             op_mtlo,
   input  logic             op_mfhi,
   input  logic             op_mflo,
   input  logic             flush,
   input  logic [WIDTH-1:0] rs_value,
   input  logic [WIDTH-1:0] rt_value,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   state_t              state_r, state_s;
   logic [CW-1:0]       count_r;
   logic [2*WIDTH-1:0]  work_r, step_s, prod_s;
   logic [WIDTH-1:0]    opnd_r, hi_r, lo_r, abs_a_s, abs_b_s, quo_s, rem_s;
   logic                sa_r, sb_r, div_r, done_r, div_zero_r;
   logic                start_s, idle_accept_s, dz_s, last_s, sa_s, sb_s, any_op_s;
   op_kind_t            start_kind_s;

   // Decode the highest-priority arithmetic request and its operand magnitudes.
   always_comb begin
      start_s      = 1'b0;
      start_kind_s = OP_MULT;
      if (op_mult) begin
         start_s      = 1'b1;
         start_kind_s = OP_MULT;
      end else if (op_multu) begin
         start_s      = 1'b1;
         start_kind_s = OP_MULTU;
      end else if (op_div) begin
         start_s      = 1'b1;
         start_kind_s = OP_DIV;
      end else if (op_divu) begin
         start_s      = 1'b1;
         start_kind_s = OP_DIVU;
      end else begin
         start_s      = 1'b0;
         start_kind_s = OP_MULT;
      end
      sa_s          = op_is_signed(start_kind_s) && rs_value[WIDTH-1];
      sb_s          = op_is_signed(start_kind_s) && rt_value[WIDTH-1];
      abs_a_s       = sa_s ? ({WIDTH{1'b0}} - rs_value) : rs_value;
      abs_b_s       = sb_s ? ({WIDTH{1'b0}} - rt_value) : rt_value;
      idle_accept_s = (state_r == S_IDLE) && !flush;
      dz_s          = start_s && op_is_div(start_kind_s) && (rt_value == {WIDTH{1'b0}});
      last_s        = (count_r == CW'(WIDTH - 1));
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div    (div_r),
      .work      (work_r),
      .opnd      (opnd_r),
      .work_next (step_s)
   );

   // Sign fix-up values written on the edge that ends the SIGN cycle.
   always_comb begin
      prod_s = (sa_r ^ sb_r) ? ({(2*WIDTH){1'b0}} - work_r) : work_r;
      quo_s  = (sa_r ^ sb_r) ? ({WIDTH{1'b0}} - work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
      rem_s  = sa_r ? ({WIDTH{1'b0}} - work_r[2*WIDTH-1:WIDTH]) : work_r[2*WIDTH-1:WIDTH];
   end

   // Next-state logic; flush returns to IDLE from anywhere.
   always_comb begin
      state_s = state_r;
      if (flush) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_s && !dz_s) begin
                  state_s = op_is_div(start_kind_s) ? S_DIV : S_MUL;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_MUL, S_DIV: begin
               if (last_s) begin
                  state_s = S_SIGN;
               end else begin
                  state_s = state_r;
               end
            end
            S_SIGN:  state_s = S_IDLE;
            default: state_s = S_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath: operand latch, iteration, HI/LO writes and status pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r    <= {CW{1'b0}};
         work_r     <= {(2*WIDTH){1'b0}};
         opnd_r     <= {WIDTH{1'b0}};
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         sa_r       <= 1'b0;
         sb_r       <= 1'b0;
         div_r      <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         if (idle_accept_s) begin
            if (dz_s) begin
               div_zero_r <= 1'b1;
            end else if (start_s) begin
               // Divide iterates on the dividend; multiply shifts out the multiplier.
               div_r   <= op_is_div(start_kind_s);
               work_r  <= {{WIDTH{1'b0}}, op_is_div(start_kind_s) ? abs_a_s : abs_b_s};
               opnd_r  <= op_is_div(start_kind_s) ? abs_b_s : abs_a_s;
               sa_r    <= sa_s;
               sb_r    <= sb_s;
               count_r <= {CW{1'b0}};
            end else if (op_mthi) begin
               hi_r <= rs_value;
            end else if (op_mtlo) begin
               lo_r <= rs_value;
            end
         end else if (flush) begin
            count_r <= {CW{1'b0}};
         end else if ((state_r == S_MUL) || (state_r == S_DIV)) begin
            work_r  <= step_s;
            count_r <= last_s ? {CW{1'b0}} : (count_r + CW'(1));
         end else if (state_r == S_SIGN) begin
            if (div_r) begin
               lo_r <= quo_s;
               hi_r <= rem_s;
            end else begin
               {hi_r, lo_r} <= prod_s;
            end
            done_r <= 1'b1;
         end
      end
   end

   always_comb begin
      any_op_s = op_mult | op_multu | op_div | op_divu | op_mthi | op_mtlo | op_mfhi | op_mflo;
      busy     = (state_r != S_IDLE);
      stall    = busy & any_op_s;
      hi       = hi_r;
      lo       = lo_r;
      done     = done_r;
      div_zero = div_zero_r;
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
   logic        op_mthi = 1'b0, op_mtlo = 1'b0, op_mfhi = 1'b0, op_mflo = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] rs_value = 32'd0, rt_value = 32'd0;
   logic [31:0] hi, lo;
   logic        busy, stall, done, div_zero;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
      .op_mthi(op_mthi), .op_mtlo(op_mtlo), .op_mfhi(op_mfhi), .op_mflo(op_mflo),
      .flush(flush), .rs_value(rs_value), .rt_value(rt_value),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results from plain 64-bit arithmetic, busy as a countdown.
   int          m_left;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_done, m_dz;
   longint      ma, mb, mp, mq, mr;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dz = 1'b0;
      end else begin
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (flush) begin
            m_left = 0;
         end else if (m_left > 1) begin
            m_left = m_left - 1;
         end else if (m_left == 1) begin
            m_left = 0; m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
         end else if (op_mult || op_multu) begin
            if (op_mult) begin
               ma = longint'($signed(rs_value)); mb = longint'($signed(rt_value));
            end else begin
               ma = longint'({32'd0, rs_value}); mb = longint'({32'd0, rt_value});
            end
            mp = ma * mb;
            {p_hi, p_lo} = mp;
            m_left = 33;
         end else if (op_div || op_divu) begin
            if (rt_value == 32'd0) begin
               m_dz = 1'b1;
            end else begin
               if (op_div) begin
                  ma = longint'($signed(rs_value)); mb = longint'($signed(rt_value));
               end else begin
                  ma = longint'({32'd0, rs_value}); mb = longint'({32'd0, rt_value});
               end
               mq = ma / mb;
               mr = ma % mb;
               p_lo = mq[31:0];
               p_hi = mr[31:0];
               m_left = 33;
            end
         end else if (op_mthi) begin
            m_hi = rs_value;
         end else if (op_mtlo) begin
            m_lo = rs_value;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("busy", 32'(busy), 32'(m_left != 0));
         chk("stall", 32'(stall), 32'((m_left != 0) && (op_mult || op_multu || op_div || op_divu ||
                                                         op_mthi || op_mtlo || op_mfhi || op_mflo)));
         chk("done", 32'(done), 32'(m_done));
         chk("div_zero", 32'(div_zero), 32'(m_dz));
      end
   end

   // ops = {mult, multu, div, divu, mthi, mtlo, mfhi, mflo}; returns at start of the cycle after accept.
   task automatic issue(input logic [7:0] ops, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock); #1;
      {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo} = ops;
      rs_value = a;
      rt_value = b;
      @(posedge clock); #1;
      {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo} = 8'd0;
   endtask

   // Cycle index (1 = cycle after accept) at which done is seen, 0 if never.
   task automatic wait_done(output int found);
      found = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (done) begin
            found = n;
            break;
         end
      end
   endtask

   int          cyc;
   logic [31:0] save_hi, save_lo;
   logic        seen;

   initial begin
      #23;
      chk("reset_hi", hi, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clock);
      chk("idle_done", 32'(done), 32'd0);

      issue(8'b0100_0000, 32'hFFFF_FFFF, 32'd2);
      wait_done(cyc);
      chk("multu_latency", 32'(cyc), 32'd34);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      issue(8'b1000_0000, 32'hFFFF_FFFF, 32'd2);
      wait_done(cyc);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);

      issue(8'b0010_0000, 32'hFFFF_FFF9, 32'd2);
      wait_done(cyc);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      issue(8'b0001_0000, 32'd7, 32'd2);
      wait_done(cyc);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);

      issue(8'b0010_0000, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc);
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'd0);

      // Divide by zero leaves HI/LO alone and never goes busy.
      issue(8'b0000_1000, 32'h0000_00AA, 32'd0);
      issue(8'b0000_0100, 32'h0000_00BB, 32'd0);
      issue(8'b0010_0000, 32'd5, 32'd0);
      @(negedge clock);
      chk("dz_pulse", 32'(div_zero), 32'd1);
      seen = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (busy) seen = 1'b1;
         @(negedge clock);
      end
      chk("dz_busy", 32'(seen), 32'd0);
      chk("dz_hi", hi, 32'h0000_00AA);
      chk("dz_lo", lo, 32'h0000_00BB);

      // mflo held from cycle 3 stalls until the done cycle.
      issue(8'b1000_0000, 32'h0000_1234, 32'h0000_0010);
      cyc = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 3) op_mflo = 1'b1;
         @(negedge clock);
         if (done) begin
            cyc = n;
            chk("mflo_stall_done", 32'(stall), 32'd0);
            break;
         end
         chk("mflo_stall", 32'(stall), 32'(n >= 3));
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      op_mflo = 1'b0;
      chk("mflo_cycle", 32'(cyc), 32'd34);
      chk("mflo_lo", lo, 32'h0001_2340);

      // Flush during cycle 10 of a divide.
      save_hi = hi;
      save_lo = lo;
      issue(8'b0010_0000, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clock); #1;
      end
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      @(negedge clock);
      chk("flush_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (done) seen = 1'b1;
         @(negedge clock);
      end
      chk("flush_done", 32'(seen), 32'd0);
      chk("flush_hi", hi, save_hi);
      chk("flush_lo", lo, save_lo);

      // Priority: mult beats div and mthi.
      issue(8'b1010_1000, 32'd3, 32'd4);
      wait_done(cyc);
      chk("prio_lo", lo, 32'd12);
      chk("prio_hi", hi, 32'd0);

      // mthi in IDLE.
      @(posedge clock); #1;
      op_mthi  = 1'b1;
      rs_value = 32'h0000_1234;
      @(negedge clock);
      chk("mthi_stall", 32'(stall), 32'd0);
      @(posedge clock); #1;
      op_mthi = 1'b0;
      @(negedge clock);
      chk("mthi_hi", hi, 32'h0000_1234);
      chk("mthi_lo", lo, 32'd12);

      // Asynchronous reset in cycle 20 of a multiply.
      issue(8'b1000_0000, 32'd9, 32'd9);
      repeat (19) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clock); #1;
      reset = 1'b0;
      repeat (3) @(negedge clock);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
